ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Parametrised, pipelined successor of the combined execute/data-memory block.
- Registers one operation per handshake. Selects the ALU operand, computes the result and the Z/N/C/V flags, and performs word loads and stores on an internal synchronous RAM.
- Sits between decode/register-read and writeback, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: datapath width in bits.
- DEPTH, 1024: data-memory words. Must be at least 8. AW = clog2(DEPTH) is a localparam.
- INIT_EN, 1: when 1, simulation initial contents of words 0..5 are 0,4,30,19,6,10; all other words are 0.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  stage can accept an operation.
- alu_op  in  3  0 ADD, 1 INC, 2 NEG, 3 SUB, 4 PASSB; 5–7 illegal.
- alu_src  in  1  1: opa = imm; 0: opa = rd2.
- mem_read  in  1  load mem[rd1].
- mem_write  in  1  store rd2 to mem[rd1].
- rd1, rd2, imm  in  WIDTH each  operands.
- out_valid  out  1  result presented.
- out_ready  in  1  downstream accepts.
- result  out  WIDTH  registered ALU result.
- read_data  out  WIDTH  registered load data.
- zero, neg, carry, ovf  out  1 each  flags of result.
- err  out  1  illegal op, out-of-range address, or read and write both set.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - state goes to IDLE.
  - out_valid, result, read_data, all flags and err go to 0.
  - Memory contents are retained.
  - Reset in the middle of an operation abandons it. A store whose acceptance edge preceded reset stays committed.
- Transfers:
  - An input transfer happens on a rising edge when in_valid && in_ready.
  - An output transfer happens on a rising edge when out_valid && out_ready.
  - Inputs are sampled only at the input-transfer edge.
- ALU (opb = rd1), all arithmetic modulo 2^WIDTH:
  - ADD: opa + opb.
  - INC: opa + 1.
  - NEG: 0 − opb.
  - SUB: opa − opb.
  - PASSB: opb.
  - Illegal op: result 0, err = 1.
- Flags:
  - zero = (result == 0); neg = result[WIDTH-1].
  - carry = carry-out for ADD/INC; for SUB/NEG it is the not-borrow (1 when no borrow, i.e. carry-out of opa + ~opb + 1); 0 for PASSB.
  - ovf = signed overflow for ADD/INC/SUB/NEG, else 0.
- Memory:
  - Address is rd1[AW-1:0]. An operation is out of range when rd1 >= DEPTH.
  - A store writes at the acceptance edge. An out-of-range store is suppressed and sets err.
  - A load reads synchronously. An out-of-range load returns 0 and sets err.
  - mem_read && mem_write together: nothing is written, read_data is unchanged, err = 1; the op still completes as an ALU op.
  - read_data holds its previous value on non-load operations.
- FSM, states IDLE, LOAD, DONE:
  - IDLE: in_ready = 1. On acceptance, a load goes to LOAD; any other op goes to DONE with result and flags registered.
  - LOAD: in_ready = 0. RAM output is captured into read_data, and result/flags are registered alongside. Next state is DONE.
  - DONE: out_valid = 1. Outputs stay stable until out_ready.
  - DONE with out_ready: in_ready = out_ready (combinational), so back-to-back accept is allowed. A new non-load goes to DONE; a new load goes to LOAD; with no new op, go to IDLE.
- Latency from acceptance to out_valid: 1 cycle for ALU ops and stores; 2 cycles for loads.
- Throughput: 1 op/cycle for non-loads; 1 load per 2 cycles.
- Read-after-write: a load accepted the cycle after a store to the same address returns the new data.

Decomposition:
- Shared package ex_pkg holds:
  - the alu_op encodings (OP_ADD..OP_PASSB);
  - the state enum;
  - the flag-bundle typedef.
- Sub-module ex_alu (combinational; parameter WIDTH; outputs result, zero, neg, carry, ovf, illegal).
- The RAM is inferred inline in ex_mem_stage.

Test Plan:
- Reset mid-LOAD (pulse reset_n low) → out_valid = 0, result = 0, state IDLE on the next edge; mem[3] is still 19.
- ADD, alu_src=1, imm=5, rd1=7 → one cycle later out_valid=1, result=12, zero=0, carry=0. SUB with rd2=3, rd1=3, alu_src=0 → result=0, zero=1, carry=1.
- Load rd1=2 → out_valid after 2 cycles, read_data=30. Hold out_ready=0 for 3 cycles → outputs stable and in_ready=0 throughout.
- Store rd1=4, rd2=99, then a load of rd1=4 on the next cycle → read_data=99. Store rd1=DEPTH → err=1 and no memory word changes.
- ADD 0x7FFFFFFF + 1 → ovf=1, neg=1, carry=0. NEG with rd1=1 → result=0xFFFFFFFF, carry=0. alu_op=6 → result=0, err=1.
- Back-to-back: four ALU ops with out_ready held 1 → four results on consecutive cycles with no bubbles. mem_read and mem_write both set → err=1 and memory unchanged.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage shared types.
// ALU opcodes, stage states, flag bundle.
package ex_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_NEG   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_PASSB = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage handshake bundle.
// Upstream op channel and downstream result channel.
interface ex_mem_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic             alu_src;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] imm;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] read_data;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid,
    output alu_op,
    output alu_src,
    output mem_read,
    output mem_write,
    output rd1,
    output rd2,
    output imm,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  read_data,
    input  zero,
    input  neg,
    input  carry,
    input  ovf,
    input  err
  );

  modport slave (
    input  in_valid,
    input  alu_op,
    input  alu_src,
    input  mem_read,
    input  mem_write,
    input  rd1,
    input  rd2,
    input  imm,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output read_data,
    output zero,
    output neg,
    output carry,
    output ovf,
    output err
  );

endinterface

// File: rtl/ex_mem_stage_alu.sv
// Combinational ALU for ex_mem_stage.
// One shared adder serves ADD, INC, NEG and SUB.
module ex_alu #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);
  import ex_pkg::*;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             arith;
  logic [WIDTH:0]   sum;

  // Map each op onto x + y + cin; subtraction uses ~opb + 1.
  always_comb begin
    x       = '0;
    y       = '0;
    cin     = 1'b0;
    arith   = 1'b1;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        x = opa;
        y = opb;
      end
      (op == OP_INC): begin
        x   = opa;
        cin = 1'b1;
      end
      (op == OP_NEG): begin
        y   = ~opb;
        cin = 1'b1;
      end
      (op == OP_SUB): begin
        x   = opa;
        y   = ~opb;
        cin = 1'b1;
      end
      (op == OP_PASSB): begin
        arith = 1'b0;
      end
      default: begin
        arith   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y}
             + {{WIDTH{1'b0}}, cin};

  // Select the result and derive flags from it.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    if (arith) begin
      result = sum[WIDTH-1:0];
      carry  = sum[WIDTH];
      ovf    = (x[WIDTH-1] == y[WIDTH-1])
             & (sum[WIDTH-1] != x[WIDTH-1]);
    end else if (!illegal) begin
      result = opb;
    end
    zero = (result == '0);
    neg  = result[WIDTH-1];
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute + data-memory pipeline stage.
// ALU ops finish in 1 cycle, loads in 2.
module ex_mem_stage #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int INIT_EN = 1
) (
  input logic   clock,
  input logic   reset_n,
  ex_mem_if.slave bus
);
  import ex_pkg::*;

  localparam int AW = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    m = '{default: '0};
    if (INIT_EN != 0) begin
      m[0] = WIDTH'(0);
      m[1] = WIDTH'(4);
      m[2] = WIDTH'(30);
      m[3] = WIDTH'(19);
      m[4] = WIDTH'(6);
      m[5] = WIDTH'(10);
    end
    return m;
  endfunction

  mem_t mem = init_mem();

  state_t state_q;
  state_t state_d;

  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             is_load;
  logic             rw_both;
  logic             oor;
  logic             op_err;
  logic             we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] opa;

  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;
  logic             alu_illegal;

  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] pend_result;
  flags_t           pend_flags;
  logic             pend_err;
  logic             pend_oor;

  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] read_data_q;
  flags_t           flags_q;
  logic             err_q;

  assign opa     = bus.alu_src ? bus.imm : bus.rd2;
  assign addr    = bus.rd1[AW-1:0];
  assign oor     = (bus.rd1 >= WIDTH'(DEPTH));
  assign rw_both = bus.mem_read & bus.mem_write;
  assign is_load = bus.mem_read & ~bus.mem_write;
  assign accept  = bus.in_valid & in_ready;
  assign we      = accept & bus.mem_write
                 & ~bus.mem_read & ~oor;
  assign op_err  = alu_illegal | rw_both
                 | ((bus.mem_read | bus.mem_write) & oor);

  ex_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op      (bus.alu_op),
    .opa     (opa),
    .opb     (bus.rd1),
    .result  (alu_res),
    .zero    (alu_flags.zero),
    .neg     (alu_flags.neg),
    .carry   (alu_flags.carry),
    .ovf     (alu_flags.ovf),
    .illegal (alu_illegal)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; DONE may accept back-to-back.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = is_load ? LOAD : DONE;
        end
      end
      LOAD: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            state_d = is_load ? LOAD : DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM: write-at-accept, synchronous read; contents survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= bus.rd2;
    end
    if (accept && is_load) begin
      ram_q <= mem[addr];
    end
  end

  // Output registers; loads park ALU results until the RAM word lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q    <= '0;
      read_data_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      pend_result <= '0;
      pend_flags  <= '0;
      pend_err    <= 1'b0;
      pend_oor    <= 1'b0;
    end else if (accept && is_load) begin
      pend_result <= alu_res;
      pend_flags  <= alu_flags;
      pend_err    <= op_err;
      pend_oor    <= oor;
    end else if (accept) begin
      result_q <= alu_res;
      flags_q  <= alu_flags;
      err_q    <= op_err;
    end else if (state_q == LOAD) begin
      result_q    <= pend_result;
      flags_q     <= pend_flags;
      err_q       <= pend_err;
      read_data_q <= pend_oor ? '0 : ram_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.read_data = read_data_q;
  assign bus.zero      = flags_q.zero;
  assign bus.neg       = flags_q.neg;
  assign bus.carry     = flags_q.carry;
  assign bus.ovf       = flags_q.ovf;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage.
// Inputs driven after posedge, outputs sampled on negedge.
module tb_ex_mem_stage;
  import ex_pkg::*;

  localparam int W = 32;
  localparam int D = 1024;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  ex_mem_if #(.WIDTH(W)) bus ();

  ex_mem_stage #(
    .WIDTH   (W),
    .DEPTH   (D),
    .INIT_EN (1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic issue(
    input logic [2:0]   op,
    input logic         src,
    input logic         mr,
    input logic         mw,
    input logic [W-1:0] a1,
    input logic [W-1:0] a2,
    input logic [W-1:0] im
  );
    @(negedge clock);
    bus.alu_op    = op;
    bus.alu_src   = src;
    bus.mem_read  = mr;
    bus.mem_write = mw;
    bus.rd1       = a1;
    bus.rd2       = a2;
    bus.imm       = im;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op    = OP_ADD;
    bus.alu_src   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.rd1       = '0;
    bus.rd2       = '0;
    bus.imm       = '0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.result !== 32'd0 || bus.read_data !== 32'd0) begin
      failures++;
      $display("FAIL rst_data got=%h/%h exp=0/0",
               bus.result, bus.read_data);
    end
    checks++;
    if (bus.err !== 1'b0 || bus.zero !== 1'b0
        || bus.carry !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b%b%b exp=000",
               bus.err, bus.zero, bus.carry);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    issue(OP_ADD, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd9);
    issue(OP_ADD, 1'b1, 1'b1, 1'b0, 32'd3, 32'd0, 32'd1);
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.result !== 32'd9) begin
      failures++;
      $display("FAIL mid_load_pre got=%b/%h exp=0/9",
               bus.in_ready, bus.result);
    end
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0
        || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_load_rst got=%b/%h/%b exp=0/0/1",
               bus.out_valid, bus.result, bus.in_ready);
    end
    issue(OP_PASSB, 1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.read_data !== 32'd19 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mem3_kept got=%0d/%b exp=19/1",
               bus.read_data, bus.out_valid);
    end
  endtask

  task automatic test_alu_basic();
    issue(OP_ADD, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 32'd5);
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd12
        || bus.zero !== 1'b0 || bus.carry !== 1'b0) begin
      failures++;
      $display("FAIL add_basic got=%b/%h/%b/%b exp=1/c/0/0",
               bus.out_valid, bus.result, bus.zero, bus.carry);
    end
    issue(OP_SUB, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0);
    @(negedge clock);
    checks++;
    if (bus.result !== 32'd0 || bus.zero !== 1'b1
        || bus.carry !== 1'b1 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL sub_zero got=%h/%b/%b/%b exp=0/1/1/0",
               bus.result, bus.zero, bus.carry, bus.ovf);
    end
  endtask

  task automatic test_load_stall();
    issue(OP_PASSB, 1'b0, 1'b1, 1'b0, 32'd2, 32'd0, 32'd0);
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_lat1 got=%b/%b exp=0/0",
               bus.out_valid, bus.in_ready);
    end
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.read_data !== 32'd30
        || bus.result !== 32'd2) begin
      failures++;
      $display("FAIL load_lat2 got=%b/%0d/%0d exp=1/30/2",
               bus.out_valid, bus.read_data, bus.result);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.read_data !== 32'd30
          || bus.result !== 32'd2 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL load_hold%0d got=%b/%0d/%0d/%b exp=1/30/2/0",
                 i, bus.out_valid, bus.read_data,
                 bus.result, bus.in_ready);
      end
    end
  endtask

  task automatic test_store_load();
    issue(OP_ADD, 1'b0, 1'b0, 1'b1, 32'd4, 32'd99, 32'd0);
    issue(OP_PASSB, 1'b0, 1'b1, 1'b0, 32'd4, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.read_data !== 32'd99 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL raw_load got=%0d/%b exp=99/0",
               bus.read_data, bus.err);
    end
    issue(OP_ADD, 1'b0, 1'b0, 1'b1, D, 32'hdead, 32'd0);
    @(negedge clock);
    checks++;
    if (bus.err !== 1'b1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL oor_store got=%b/%b exp=1/1",
               bus.err, bus.out_valid);
    end
    issue(OP_PASSB, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.read_data !== 32'd0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL oor_no_alias got=%h/%b exp=0/0",
               bus.read_data, bus.err);
    end
    issue(OP_PASSB, 1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 32'd0);
    @(negedge clock);
    issue(OP_PASSB, 1'b0, 1'b1, 1'b0, D + 3, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.read_data !== 32'd0 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL oor_load got=%h/%b exp=0/1",
               bus.read_data, bus.err);
    end
  endtask

  task automatic test_flags();
    issue(OP_ADD, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'h7fffffff);
    @(negedge clock);
    checks++;
    if (bus.result !== 32'h80000000 || bus.ovf !== 1'b1
        || bus.neg !== 1'b1 || bus.carry !== 1'b0) begin
      failures++;
      $display("FAIL add_ovf got=%h/%b%b%b exp=80000000/110",
               bus.result, bus.ovf, bus.neg, bus.carry);
    end
    issue(OP_NEG, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0);
    @(negedge clock);
    checks++;
    if (bus.result !== 32'hffffffff || bus.carry !== 1'b0
        || bus.ovf !== 1'b0 || bus.neg !== 1'b1) begin
      failures++;
      $display("FAIL neg_one got=%h/%b%b%b exp=ffffffff/001",
               bus.result, bus.carry, bus.ovf, bus.neg);
    end
    issue(OP_INC, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'hffffffff);
    @(negedge clock);
    checks++;
    if (bus.result !== 32'd0 || bus.carry !== 1'b1
        || bus.zero !== 1'b1 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL inc_wrap got=%h/%b%b%b exp=0/110",
               bus.result, bus.carry, bus.zero, bus.ovf);
    end
    issue(3'd6, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd5);
    @(negedge clock);
    checks++;
    if (bus.result !== 32'd0 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_op got=%h/%b exp=0/1",
               bus.result, bus.err);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ops [4];
    logic [W-1:0] a1s [4];
    logic [W-1:0] ims [4];
    logic [W-1:0] exp [4];
    ops = '{OP_ADD, OP_INC, OP_PASSB, OP_SUB};
    a1s = '{32'd2, 32'd0, 32'd77, 32'd5};
    ims = '{32'd1, 32'd10, 32'd0, 32'd20};
    exp = '{32'd3, 32'd11, 32'd77, 32'd15};
    @(negedge clock);
    bus.out_ready = 1'b1;
    bus.alu_src   = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.rd2       = '0;
    for (int i = 0; i < 4; i++) begin
      bus.alu_op   = ops[i];
      bus.rd1      = a1s[i];
      bus.imm      = ims[i];
      bus.in_valid = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp[i]) begin
        failures++;
        $display("FAIL b2b_%0d got=%b/%0d exp=1/%0d",
                 i, bus.out_valid, bus.result, exp[i]);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got=%b exp=0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_rw_both();
    issue(OP_PASSB, 1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.read_data !== 32'd10) begin
      failures++;
      $display("FAIL rw_pre got=%0d exp=10", bus.read_data);
    end
    issue(OP_ADD, 1'b1, 1'b1, 1'b1, 32'd5, 32'h1234, 32'd1);
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.err !== 1'b1
        || bus.result !== 32'd6 || bus.read_data !== 32'd10) begin
      failures++;
      $display("FAIL rw_both got=%b/%b/%0d/%0d exp=1/1/6/10",
               bus.out_valid, bus.err, bus.result, bus.read_data);
    end
    issue(OP_PASSB, 1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.read_data !== 32'd10 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL rw_mem_kept got=%h/%b exp=a/0",
               bus.read_data, bus.err);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_reset_mid_load();
    test_alu_basic();
    test_load_stall();
    test_store_load();
    test_flags();
    test_back_to_back();
    test_rw_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
